// File: rtl/target_io_bridge_if.sv
// Board/register-file signal bundle for target_io_bridge.
// master: the side driving raw board inputs and register-file reads.
// slave:  the bridge itself.
interface target_io_bridge_if;
    logic        button_raw;
    logic        t1_sensor_raw;
    logic        t2_sensor_raw;
    logic [31:0] t1active_read;
    logic [31:0] t2active_read;
    logic [31:0] score_read;
    logic [31:0] bp_write;
    logic [31:0] t1hit_write;
    logic [31:0] t2hit_write;
    logic [31:0] timer1_write;
    logic [31:0] timer2_write;
    logic [31:0] gametimer_write;
    logic [15:0] score_disp;
    logic        game_over;

    modport master (
        output button_raw, t1_sensor_raw, t2_sensor_raw,
        output t1active_read, t2active_read, score_read,
        input  bp_write, t1hit_write, t2hit_write,
        input  timer1_write, timer2_write, gametimer_write,
        input  score_disp, game_over
    );

    modport slave (
        input  button_raw, t1_sensor_raw, t2_sensor_raw,
        input  t1active_read, t2active_read, score_read,
        output bp_write, t1hit_write, t2hit_write,
        output timer1_write, timer2_write, gametimer_write,
        output score_disp, game_over
    );
endinterface

// File: rtl/target_io_bridge.sv
// target_io_bridge: hardware side of the memory-mapped game registers.
// Synchronises button and target sensors, runs the game countdown and
// two independent target FSMs, and feeds status back to the register file.
// Optional macro DEBOUNCE_EN adds a stability counter on every input.
module target_io_bridge #(
    parameter int TICK_DIV        = 50000,
    parameter int TARGET_MS       = 2000,
    parameter int GAME_MS         = 60000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    target_io_bridge_if.slave io
);
    localparam int          PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [31:0] GAME_MS_W   = 32'(GAME_MS);
    localparam logic [31:0] TARGET_MS_W = 32'(TARGET_MS);

    typedef enum logic [1:0] {G_IDLE = 2'd0, G_RUN = 2'd1, G_OVER = 2'd2} game_state_t;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HIT = 2'd2, MISS = 2'd3} tgt_state_t;

    // bit 0 = button, bit 1 = target-1 sensor, bit 2 = target-2 sensor
    logic [2:0]    raw_s;
    logic [2:0]    sync1_r;
    logic [2:0]    sync2_r;
    logic [2:0]    level_s;
    logic [2:0]    prev_r;
    logic [2:0]    rise_s;
    logic [1:0]    active_s;
    logic [PW-1:0] presc_r;
    logic          ms_tick_s;
    logic          game_end_s;
    game_state_t   game_r;
    logic [31:0]   gametimer_r;
    logic          game_over_r;
    tgt_state_t    tgt_r   [2];
    logic [31:0]   hit_r   [2];
    logic [31:0]   timer_r [2];
    logic          bp_r;
    logic [15:0]   score_r;
    logic          unused_s;

    assign raw_s    = {io.t2_sensor_raw, io.t1_sensor_raw, io.button_raw};
    assign active_s = {io.t2active_read[0], io.t1active_read[0]};
    assign unused_s = ^{io.t1active_read[31:1], io.t2active_read[31:1]};

    // Two-flop synchroniser on every raw board input
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] deb_cnt_r [3];
    logic [2:0]    deb_level_r;

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive cycles at the new value
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= '0;
            end
            deb_level_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == deb_level_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_level_r[i] <= sync2_r[i];
                    deb_cnt_r[i]   <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
                end
            end
        end
    end

    assign level_s = deb_level_r;
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;

    assign level_s = sync2_r;
`endif

    assign rise_s = level_s & ~prev_r;

    // Previous level for edge detect, plus the registered button level
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            prev_r <= 3'b000;
            bp_r   <= 1'b0;
        end else begin
            prev_r <= level_s;
            bp_r   <= level_s[0];
        end
    end

    assign ms_tick_s = (presc_r == PW'(TICK_DIV - 1));

    // Free-running millisecond prescaler
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            presc_r <= '0;
        end else if (ms_tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // The game ends on the tick that takes the countdown to zero
    assign game_end_s = (game_r == G_RUN) && ms_tick_s && (gametimer_r <= 32'd1);

    // Game FSM: idle -> countdown -> over, button edges advance it
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            game_r      <= G_IDLE;
            gametimer_r <= GAME_MS_W;
            game_over_r <= 1'b0;
        end else begin
            case (game_r)
                G_IDLE: begin
                    gametimer_r <= GAME_MS_W;
                    game_over_r <= 1'b0;
                    if (rise_s[0]) begin
                        game_r <= G_RUN;
                    end else begin
                        game_r <= G_IDLE;
                    end
                end
                G_RUN: begin
                    if (game_end_s) begin
                        gametimer_r <= 32'd0;
                        game_over_r <= 1'b1;
                        game_r      <= G_OVER;
                    end else if (ms_tick_s) begin
                        gametimer_r <= gametimer_r - 32'd1;
                    end else begin
                        gametimer_r <= gametimer_r;
                    end
                end
                G_OVER: begin
                    if (rise_s[0]) begin
                        game_r      <= G_IDLE;
                        gametimer_r <= GAME_MS_W;
                        game_over_r <= 1'b0;
                    end else begin
                        game_over_r <= 1'b1;
                    end
                end
                default: begin
                    game_r      <= G_IDLE;
                    gametimer_r <= GAME_MS_W;
                    game_over_r <= 1'b0;
                end
            endcase
        end
    end

    // Target FSMs; dropping the active bit or leaving G_RUN beats a same-cycle hit
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < 2; i++) begin
                tgt_r[i]   <= IDLE;
                hit_r[i]   <= 32'd0;
                timer_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!active_s[i] || game_end_s || (game_r != G_RUN)) begin
                    tgt_r[i]   <= IDLE;
                    hit_r[i]   <= 32'd0;
                    timer_r[i] <= 32'd0;
                end else begin
                    case (tgt_r[i])
                        IDLE: begin
                            tgt_r[i]   <= ARMED;
                            hit_r[i]   <= 32'd0;
                            timer_r[i] <= 32'd0;
                        end
                        ARMED: begin
                            if (rise_s[i + 1]) begin
                                tgt_r[i] <= HIT;
                                hit_r[i] <= 32'd1;
                            end else if (timer_r[i] == TARGET_MS_W) begin
                                tgt_r[i] <= MISS;
                                hit_r[i] <= 32'd2;
                            end else if (ms_tick_s && (timer_r[i] < TARGET_MS_W)) begin
                                timer_r[i] <= timer_r[i] + 32'd1;
                            end else begin
                                timer_r[i] <= timer_r[i];
                            end
                        end
                        HIT, MISS: begin
                            tgt_r[i] <= tgt_r[i];
                        end
                        default: begin
                            tgt_r[i]   <= IDLE;
                            hit_r[i]   <= 32'd0;
                            timer_r[i] <= 32'd0;
                        end
                    endcase
                end
            end
        end
    end

    // Score display register, saturating when the upper half is non-zero
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            score_r <= 16'd0;
        end else if (io.score_read[31:16] != 16'd0) begin
            score_r <= 16'hFFFF;
        end else begin
            score_r <= io.score_read[15:0];
        end
    end

    assign io.bp_write        = {31'd0, bp_r};
    assign io.t1hit_write     = hit_r[0];
    assign io.t2hit_write     = hit_r[1];
    assign io.timer1_write    = timer_r[0];
    assign io.timer2_write    = timer_r[1];
    assign io.gametimer_write = gametimer_r;
    assign io.score_disp      = score_r;
    assign io.game_over       = game_over_r;
endmodule

// File: tb/tb_target_io_bridge.sv
// Scoreboard bench for target_io_bridge (TICK_DIV=4, TARGET_MS=5, GAME_MS=20).
// Stimulus pushes time-tagged expectations; the monitor compares them on the
// falling edge after the tagged rising edge.
module tb_target_io_bridge;
    localparam int S_BP = 0, S_T1H = 1, S_T2H = 2, S_TM1 = 3, S_TM2 = 4, S_GT = 5, S_SD = 6, S_GO = 7;

    typedef struct {
        int          tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clock;
    logic ctrl_reset_n;
    int   tcount;
    int   base;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    target_io_bridge_if io();

    target_io_bridge #(
        .TICK_DIV(4),
        .TARGET_MS(5),
        .GAME_MS(20),
        .DEBOUNCE_CYCLES(500000)
    ) dut (
        .clock(clock),
        .ctrl_reset_n(ctrl_reset_n),
        .io(io)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Global rising-edge counter used to tag expectations
    always @(posedge clock) tcount <= tcount + 1;

    function automatic string out_name(input int sel);
        case (sel)
            S_BP:    return "bp_write";
            S_T1H:   return "t1hit_write";
            S_T2H:   return "t2hit_write";
            S_TM1:   return "timer1_write";
            S_TM2:   return "timer2_write";
            S_GT:    return "gametimer_write";
            S_SD:    return "score_disp";
            S_GO:    return "game_over";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            S_BP:    return io.bp_write;
            S_T1H:   return io.t1hit_write;
            S_T2H:   return io.t2hit_write;
            S_TM1:   return io.timer1_write;
            S_TM2:   return io.timer2_write;
            S_GT:    return io.gametimer_write;
            S_SD:    return {16'd0, io.score_disp};
            S_GO:    return {31'd0, io.game_over};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation whose tag matches the current edge count
    always @(negedge clock) begin
        int i;
        logic [31:0] act;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].tag <= tcount) begin
                act = get_out(sb_q[i].sel);
                checks = checks + 1;
                if (sb_q[i].tag < tcount) begin
                    failures = failures + 1;
                    $display("FAIL %s stale expectation tag=%0d now=%0d", out_name(sb_q[i].sel), sb_q[i].tag, tcount);
                end else if (act !== sb_q[i].val) begin
                    failures = failures + 1;
                    $display("FAIL %s at n=%0d actual=%0d expected=%0d", out_name(sb_q[i].sel), tcount - base, act, sb_q[i].val);
                end
                sb_q.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    task automatic exp_at(input int n, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = base + n;
        e.sel = sel;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic wait_to(input int n);
        while ((tcount - base) < n) @(negedge clock);
    endtask

    task automatic clear_inputs();
        io.button_raw    = 1'b0;
        io.t1_sensor_raw = 1'b0;
        io.t2_sensor_raw = 1'b0;
        io.t1active_read = 32'd0;
        io.t2active_read = 32'd0;
        io.score_read    = 32'd0;
    endtask

    // Reset, then release on a falling edge; n counts rising edges since release
    task automatic do_reset();
        @(negedge clock);
        ctrl_reset_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clock);
        ctrl_reset_n = 1'b1;
        base = tcount;
    endtask

    // Button high for one cycle after edge 1: game enters G_RUN at edge 4
    task automatic press_start();
        wait_to(1);
        io.button_raw = 1'b1;
        wait_to(2);
        io.button_raw = 1'b0;
    endtask

    initial begin
        tcount = 0;
        base = 0;
        checks = 0;
        failures = 0;
        ctrl_reset_n = 1'b0;
        clear_inputs();

        // A: reset values, full game countdown, restart
        do_reset();
        for (int s = 0; s < 8; s++) begin
            exp_at(1, s, (s == S_GT) ? 32'd20 : 32'd0);
        end
        exp_at(3, S_BP, 32'd0);
        exp_at(4, S_BP, 32'd1);
        exp_at(5, S_BP, 32'd0);
        exp_at(4, S_GT, 32'd20);
        exp_at(8, S_GT, 32'd19);
        exp_at(12, S_GT, 32'd18);
        exp_at(80, S_GT, 32'd1);
        exp_at(83, S_GO, 32'd0);
        exp_at(84, S_GT, 32'd0);
        exp_at(84, S_GO, 32'd1);
        exp_at(88, S_GT, 32'd0);
        exp_at(92, S_GO, 32'd1);
        exp_at(93, S_GO, 32'd0);
        exp_at(93, S_GT, 32'd20);
        exp_at(100, S_GT, 32'd20);
        press_start();
        wait_to(90);
        io.button_raw = 1'b1;
        wait_to(91);
        io.button_raw = 1'b0;
        wait_to(101);

        // B: target 1 hit at 3 ms, then acknowledge
        do_reset();
        exp_at(4, S_T1H, 32'd0);
        exp_at(7, S_TM1, 32'd0);
        exp_at(8, S_TM1, 32'd1);
        exp_at(12, S_TM1, 32'd2);
        exp_at(16, S_TM1, 32'd3);
        exp_at(17, S_T1H, 32'd0);
        exp_at(18, S_T1H, 32'd1);
        exp_at(18, S_TM1, 32'd3);
        exp_at(18, S_GT, 32'd17);
        exp_at(30, S_TM1, 32'd3);
        exp_at(30, S_T1H, 32'd1);
        exp_at(30, S_T2H, 32'd0);
        exp_at(30, S_TM2, 32'd0);
        exp_at(32, S_T1H, 32'd0);
        exp_at(32, S_TM1, 32'd0);
        exp_at(36, S_TM1, 32'd0);
        press_start();
        wait_to(4);
        io.t1active_read = 32'd1;
        wait_to(15);
        io.t1_sensor_raw = 1'b1;
        wait_to(16);
        io.t1_sensor_raw = 1'b0;
        wait_to(31);
        io.t1active_read = 32'd0;
        wait_to(37);

        // C: target 2 timeout at 5 ms, later sensor pulse ignored
        do_reset();
        exp_at(20, S_TM2, 32'd4);
        exp_at(24, S_TM2, 32'd5);
        exp_at(24, S_T2H, 32'd0);
        exp_at(25, S_T2H, 32'd2);
        exp_at(25, S_TM2, 32'd5);
        exp_at(32, S_T2H, 32'd2);
        exp_at(32, S_TM2, 32'd5);
        exp_at(40, S_T2H, 32'd2);
        exp_at(40, S_TM2, 32'd5);
        exp_at(40, S_T1H, 32'd0);
        exp_at(40, S_TM1, 32'd0);
        press_start();
        wait_to(4);
        io.t2active_read = 32'd1;
        wait_to(27);
        io.t2_sensor_raw = 1'b1;
        wait_to(28);
        io.t2_sensor_raw = 1'b0;
        wait_to(41);

        // D: active drop on the hit edge wins; score saturation
        do_reset();
        exp_at(17, S_TM1, 32'd3);
        exp_at(18, S_T1H, 32'd0);
        exp_at(18, S_TM1, 32'd0);
        exp_at(20, S_T1H, 32'd0);
        exp_at(21, S_SD, 32'h0000_FFFF);
        exp_at(22, S_SD, 32'd42);
        exp_at(23, S_SD, 32'h0000_FFFF);
        exp_at(24, S_SD, 32'h0000_1234);
        exp_at(25, S_SD, 32'h0000_FFFF);
        press_start();
        wait_to(4);
        io.t1active_read = 32'd1;
        wait_to(15);
        io.t1_sensor_raw = 1'b1;
        wait_to(16);
        io.t1_sensor_raw = 1'b0;
        wait_to(17);
        io.t1active_read = 32'd0;
        wait_to(20);
        io.score_read = 32'h0001_0000;
        wait_to(21);
        io.score_read = 32'd42;
        wait_to(22);
        io.score_read = 32'h0000_FFFF;
        wait_to(23);
        io.score_read = 32'h0000_1234;
        wait_to(24);
        io.score_read = 32'hFFFF_0001;
        wait_to(26);

        // F: asynchronous reset mid-game with target 1 armed
        do_reset();
        exp_at(6, S_SD, 32'd42);
        exp_at(10, S_TM1, 32'd1);
        exp_at(10, S_GT, 32'd19);
        press_start();
        wait_to(4);
        io.t1active_read = 32'd1;
        wait_to(5);
        io.score_read = 32'd42;
        wait_to(11);
        for (int s = 0; s < 8; s++) begin
            exp_at(12, s, (s == S_GT) ? 32'd20 : 32'd0);
        end
        @(posedge clock);
        #2;
        ctrl_reset_n = 1'b0;
        @(negedge clock);
        clear_inputs();
        repeat (2) @(negedge clock);
        ctrl_reset_n = 1'b1;
        base = tcount;
        exp_at(1, S_TM1, 32'd0);
        exp_at(8, S_GT, 32'd20);
        wait_to(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
